// File: rtl/shift_pipe_unit.sv
// Pipelined log shifter/rotator with a global valid/ready stall.
// Each mux level shifts by a power of two, and a pipeline register follows every REG_EVERY levels.
module shift_pipe_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned REG_EVERY = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] D,
    input  logic [31:0]      S,
    input  logic [2:0]       OP,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Y,
    output logic             ZERO,
    output logic             ERR
);

    localparam int unsigned SW  = $clog2(WIDTH);
    localparam int unsigned LAT = (SW + REG_EVERY - 1) / REG_EVERY;

    localparam logic [2:0] OpSrl = 3'b000;
    localparam logic [2:0] OpSll = 3'b001;
    localparam logic [2:0] OpSra = 3'b010;
    localparam logic [2:0] OpRor = 3'b011;
    localparam logic [2:0] OpRol = 3'b100;

    typedef struct packed {
        logic             valid;
        logic [2:0]       op;
        logic [SW-1:0]    amt;
        logic             sign;
        logic             oor;
        logic             err;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t in_stage;
    stage_t stage_in [LAT];
    stage_t stage_d  [LAT];
    stage_t stage_q  [LAT];
    logic   zero_d, zero_q;
    logic   advance;

    // One mux level: shift/rotate by 2^k with the fill selected by the operation.
    function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] din,
                                                     input logic [2:0]       op,
                                                     input logic             sign,
                                                     input int               k);
        int unsigned      sh;
        logic [WIDTH-1:0] fill;
        logic [WIDTH-1:0] r;
        sh   = 32'd1 << k;
        fill = {WIDTH{sign}};
        case (op)
            OpSrl:   r = din >> sh;
            OpSll:   r = din << sh;
            OpSra:   r = (din >> sh) | (fill << (WIDTH - sh));
            OpRor:   r = (din >> sh) | (din << (WIDTH - sh));
            OpRol:   r = (din << sh) | (din >> (WIDTH - sh));
            default: r = din;
        endcase
        return r;
    endfunction

    // Input decode: the range check needs the full 32-bit amount, so it is resolved here.
    always_comb begin
        in_stage       = '0;
        in_stage.valid = IN_VALID;
        in_stage.op    = OP;
        in_stage.data  = D;
        in_stage.sign  = D[WIDTH-1];
        case (OP)
            OpSrl, OpSll, OpSra: begin
                in_stage.amt = S[SW-1:0];
                in_stage.oor = (S >= 32'(WIDTH));
            end
            OpRor, OpRol: begin
                in_stage.amt = S[SW-1:0];
            end
            default: begin
                in_stage.err = 1'b1;
            end
        endcase
    end

    always_comb begin
        stage_in[0] = in_stage;
        for (int s = 1; s < int'(LAT); s++) begin
            stage_in[s] = stage_q[s-1];
        end
    end

    always_comb begin
        stage_t cur;
        for (int s = 0; s < int'(LAT); s++) begin
            cur = stage_in[s];
            for (int k = 0; k < int'(SW); k++) begin
                if ((k / int'(REG_EVERY)) == s && cur.amt[k]) begin
                    cur.data = shift_level(cur.data, cur.op, cur.sign, k);
                end
            end
            // Out-of-range logical/arithmetic shifts override whatever the levels produced.
            if (s == int'(LAT) - 1 && cur.oor) begin
                cur.data = (cur.op == OpSra) ? {WIDTH{cur.sign}} : '0;
            end
            stage_d[s] = cur;
        end
    end

    assign zero_d = (stage_d[LAT-1].data == '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int s = 0; s < int'(LAT); s++) begin
                stage_q[s] <= '0;
            end
            zero_q <= 1'b0;
        end else if (advance) begin
            for (int s = 0; s < int'(LAT); s++) begin
                stage_q[s] <= stage_d[s];
            end
            zero_q <= zero_d;
        end
    end

    assign advance   = ~stage_q[LAT-1].valid | OUT_READY;
    assign IN_READY  = advance;
    assign OUT_VALID = stage_q[LAT-1].valid;
    assign Y         = stage_q[LAT-1].data;
    assign ERR       = stage_q[LAT-1].err;
    assign ZERO      = zero_q;

endmodule

// File: tb/tb_shift_pipe_unit.sv
// Directed bench for shift_pipe_unit: a 32-bit single-level-per-stage instance
// and an 8-bit two-levels-per-stage instance share one clock and reset.
module tb_shift_pipe_unit;

    localparam logic [2:0] SRL = 3'b000;
    localparam logic [2:0] SLL = 3'b001;
    localparam logic [2:0] SRA = 3'b010;
    localparam logic [2:0] ROR = 3'b011;
    localparam logic [2:0] ROL = 3'b100;

    logic        clk, rst;
    logic        iv, ir, ov, ordy, zero, err;
    logic [31:0] d, s, y;
    logic [2:0]  op;

    logic        iv8, ir8, ov8, ordy8, zero8, err8;
    logic [7:0]  d8, y8;
    logic [31:0] s8;
    logic [2:0]  op8;

    int n_cmp = 0;
    int n_bad = 0;

    shift_pipe_unit #(.WIDTH(32), .REG_EVERY(1)) u_dut32 (
        .CLK(clk), .RST(rst), .IN_VALID(iv), .IN_READY(ir), .D(d), .S(s), .OP(op),
        .OUT_VALID(ov), .OUT_READY(ordy), .Y(y), .ZERO(zero), .ERR(err)
    );

    shift_pipe_unit #(.WIDTH(8), .REG_EVERY(2)) u_dut8 (
        .CLK(clk), .RST(rst), .IN_VALID(iv8), .IN_READY(ir8), .D(d8), .S(s8), .OP(op8),
        .OUT_VALID(ov8), .OUT_READY(ordy8), .Y(y8), .ZERO(zero8), .ERR(err8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req32(input string tag, input logic [2:0] o, input logic [31:0] dv,
                         input logic [31:0] sv, input logic [31:0] ey, input logic ez,
                         input logic ee);
        int n;
        op = o; d = dv; s = sv; iv = 1'b1;
        tick;
        iv = 1'b0;
        n  = 1;
        while (!ov && n < 20) begin
            tick;
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'd5);
        check({tag, "_y"}, 64'(y), 64'(ey));
        check({tag, "_zero"}, 64'(zero), 64'(ez));
        check({tag, "_err"}, 64'(err), 64'(ee));
        tick;
    endtask

    task automatic req8(input string tag, input logic [2:0] o, input logic [7:0] dv,
                        input logic [31:0] sv, input logic [7:0] ey, input logic ez,
                        input logic ee);
        int n;
        op8 = o; d8 = dv; s8 = sv; iv8 = 1'b1;
        tick;
        iv8 = 1'b0;
        n   = 1;
        while (!ov8 && n < 20) begin
            tick;
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'd2);
        check({tag, "_y"}, 64'(y8), 64'(ey));
        check({tag, "_zero"}, 64'(zero8), 64'(ez));
        check({tag, "_err"}, 64'(err8), 64'(ee));
        tick;
    endtask

    initial begin
        int issued, recv, vcnt;
        logic acc, dlv;

        rst = 1'b1;
        iv = 1'b0; d = '0; s = '0; op = SRL; ordy = 1'b1;
        iv8 = 1'b0; d8 = '0; s8 = '0; op8 = SRL; ordy8 = 1'b1;

        // Reset values before any clock edge.
        #2;
        check("rst_out_valid", 64'(ov), 64'd0);
        check("rst_y", 64'(y), 64'd0);
        check("rst_zero", 64'(zero), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        tick;
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(ir), 64'd1);

        req32("sll31", SLL, 32'h0000_0001, 32'd31, 32'h8000_0000, 1'b0, 1'b0);
        req32("sra4", SRA, 32'h8000_00F0, 32'd4, 32'hF800_000F, 1'b0, 1'b0);
        req32("sra40", SRA, 32'h8000_00F0, 32'd40, 32'hFFFF_FFFF, 1'b0, 1'b0);
        req32("srl40", SRL, 32'h8000_00F0, 32'd40, 32'h0000_0000, 1'b1, 1'b0);
        req32("sll32", SLL, 32'h0000_0001, 32'd32, 32'h0000_0000, 1'b1, 1'b0);
        req32("srl31", SRL, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, 1'b0);
        req32("sra0", SRA, 32'h8000_0001, 32'd0, 32'h8000_0001, 1'b0, 1'b0);
        req32("ror8", ROR, 32'h1234_5678, 32'd8, 32'h7812_3456, 1'b0, 1'b0);
        req32("rol36", ROL, 32'h1234_5678, 32'd36, 32'h2345_6781, 1'b0, 1'b0);
        req32("rsvd", 3'b110, 32'h1234_5678, 32'd5, 32'h1234_5678, 1'b0, 1'b1);

        // Streaming with a 3-cycle OUT_READY stall.
        issued = 0;
        recv   = 0;
        for (int c = 0; c < 40 && recv < 8; c++) begin
            ordy = !(c >= 6 && c <= 8);
            iv   = (issued < 8);
            d    = 32'd1;
            s    = 32'(issued);
            op   = SLL;
            #1;
            acc = iv && ir;
            dlv = ov && ordy;
            if (ov) begin
                check("stream_y", 64'(y), 64'(32'd1 << recv));
            end
            if (ov && !ordy) begin
                check("stall_in_ready", 64'(ir), 64'd0);
            end
            if (dlv) recv++;
            if (acc) issued++;
            tick;
        end
        iv   = 1'b0;
        ordy = 1'b1;
        check("stream_recv", 64'(recv), 64'd8);
        check("stream_issued", 64'(issued), 64'd8);
        vcnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (ov) vcnt++;
            tick;
        end
        check("stream_no_extra", 64'(vcnt), 64'd0);

        // Reset with three requests in flight and the head result stalled at the output.
        ordy = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            iv = 1'b1; d = 32'd1; s = 32'(c); op = SLL;
            tick;
        end
        iv = 1'b0;
        tick;
        tick;
        check("inflight_valid", 64'(ov), 64'd1);
        check("inflight_y", 64'(y), 64'd2);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(ov), 64'd0);
        check("midrst_y", 64'(y), 64'd0);
        check("midrst_zero", 64'(zero), 64'd0);
        #2;
        rst  = 1'b0;
        ordy = 1'b1;
        vcnt = 0;
        for (int c = 0; c < 12; c++) begin
            tick;
            if (ov) vcnt++;
        end
        check("post_rst_stale", 64'(vcnt), 64'd0);

        // 8-bit, two mux levels per register.
        req8("w8_sra3", SRA, 8'h90, 32'd3, 8'hF2, 1'b0, 1'b0);
        req8("w8_ror9", ROR, 8'h81, 32'd9, 8'hC0, 1'b0, 1'b0);
        req8("w8_sll8", SLL, 8'h81, 32'd8, 8'h00, 1'b1, 1'b0);
        req8("w8_rol3", ROL, 8'h81, 32'd3, 8'h0C, 1'b0, 1'b0);
        req8("w8_rsvd", 3'b111, 8'h5A, 32'd2, 8'h5A, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_pipe_unit.md
Name: shift_pipe_unit

Overview:
Parametrised, pipelined shift/rotate unit for the ALU datapath. It is the successor to the 32-bit combinational shifter and adds configurable width, arithmetic right shift, rotates, and pipeline registers between mux levels. A valid/ready handshake with backpressure lets the unit sit between the register-read stage and the write-back mux.

Parameters:
- WIDTH, 32, data width; must be a power of two, 8..64.
- REG_EVERY, 1, number of log-shifter mux levels between pipeline registers; 1..SW.
- SW, derived = clog2(WIDTH), number of mux levels. Not user-set.
- LAT, derived = ceil(SW/REG_EVERY), pipeline latency in cycles.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- IN_VALID  input  1  request valid.
- IN_READY  output  1  unit accepts a request this cycle.
- D  input  WIDTH  operand.
- S  input  32  shift amount; the full 32-bit value is significant.
- OP  input  3  operation: 000 SRL, 001 SLL, 010 SRA, 011 ROR, 100 ROL, 101..111 reserved.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  consumer accepts the result.
- Y  output  WIDTH  result.
- ZERO  output  1  Y equals 0; qualified by OUT_VALID.
- ERR  output  1  reserved OP was used; qualified by OUT_VALID.

Behaviour:
- Reset (async, RST=1):
  - All stage valid bits clear.
  - OUT_VALID=0, Y=0, ZERO=0, ERR=0.
  - IN_READY=1 once RST deasserts.
  - A request in flight when RST asserts is discarded, with no partial output.
- Handshake:
  - Request accepted when IN_VALID & IN_READY.
  - Result delivered when OUT_VALID & OUT_READY.
  - Global stall: advance = ~OUT_VALID | OUT_READY; IN_READY = advance (combinational).
  - When advance=0, every stage register, including its data/OP/valid, holds.
  - Y, ZERO and ERR are stable while OUT_VALID=1 & OUT_READY=0.
- Throughput and latency:
  - One request per cycle when there is no backpressure.
  - A request accepted in cycle t produces OUT_VALID in cycle t+LAT, given advance=1 throughout.
  - Bubbles (no accept) propagate as valid=0 stages. No bubble collapsing is required.
- Mux levels:
  - Level k shifts by 2^k when amount bit k is set, for k=0..SW-1.
  - Fill bits per mode: SRL zero; SLL zero; SRA D[WIDTH-1], captured at input and carried down the pipe; ROR/ROL wrap bits.
  - A register follows every REG_EVERY levels, with the final register driving Y. If SW is not a multiple of REG_EVERY, the last segment has fewer levels.
- Out-of-range shift amount (S >= WIDTH), decided at input and carried as a flag:
  - SRL/SLL: Y=0.
  - SRA: Y = all copies of the sign bit.
  - ROR/ROL: amount = S mod WIDTH (low SW bits only).
- S=0: Y=D for every valid OP.
- Reserved OP: Y=D, ERR=1.
- ZERO is computed from the final Y in the output stage (registered together with Y).
- Simultaneous accept and deliver in the same cycle is legal and is the normal streaming case.
- Reset value of every output applies after RST regardless of CLK activity.

Test Plan:
- WIDTH=32, REG_EVERY=1 (LAT=5), OUT_READY=1; SLL D=0x0000_0001 S=31 -> Y=0x8000_0000 exactly 5 cycles after accept, ZERO=0.
- SRA D=0x8000_00F0 S=4 -> Y=0xF800_000F; SRA S=40 -> Y=0xFFFF_FFFF; SRL S=40 -> Y=0, ZERO=1.
- ROR D=0x1234_5678 S=8 -> 0x7812_3456; ROL S=36 -> 0x2345_6781; OP=110 -> Y=0x1234_5678, ERR=1.
- Streaming with backpressure: issue 8 back-to-back SLL S=i (i=0..7) on D=1 and hold OUT_READY=0 for 3 cycles mid-stream -> IN_READY=0 while stalled, outputs arrive in order 1,2,4,...,0x80 with none lost or duplicated, and Y stays stable during the stall.
- Reset mid-operation: assert RST asynchronously (between edges) with 3 requests in flight -> OUT_VALID/Y drop to 0 immediately, and no stale result appears after release.
- WIDTH=8, REG_EVERY=2 (LAT=2): SRA D=0x90 S=3 -> Y=0xF2 after 2 cycles; ROR D=0x81 S=9 -> Y=0xC0.
